// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: exception type/codes and fetch FSM states shared by the fetch controller files.
package fetch_controller_pkg;

    localparam logic [4:0] INSTR_ADDR_MISALIGNED = 5'd0;
    localparam logic [4:0] INSTR_ACCESS_FAULT    = 5'd1;

    typedef struct packed {
        logic       raise;
        logic [4:0] code;
    } exception_t;

    typedef enum logic [2:0] {REQ, WAIT, OUT, DRAIN, FAULT} fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter: saturating fetch-stall cycle counter and squash counter.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_inc,
    input  logic        squash_inc,
    output logic [31:0] stall_cycles,
    output logic [15:0] squash_count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            squash_count <= '0;
        end else begin
            if (stall_inc && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
            if (squash_inc && !(&squash_count)) squash_count <= squash_count + 16'd1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC owner and single-outstanding imem fetch sequencer feeding IF_ID.
// Optional FETCH_PERF_CNT_EN adds fetch_stall_cycles / squash_count outputs.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          MISALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall_id,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        valid_if,
    output logic [31:0] instruction_addr_if,
    output logic [31:0] instruction_if,
    output exception_t  exception_if
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cycles,
    output logic [15:0] squash_count
`endif
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, instr_n, addr_n;
    exception_t   exc_n;
    logic         mis_q, mis_n, mis_tgt, busy;

    assign mis_tgt   = MISALIGN_CHECK && (redirect_pc[1:0] != 2'b00);
    // A granted request whose response has not yet arrived must be drained.
    assign busy      = (state == REQ && imem_gnt) ||
                       ((state == WAIT || state == DRAIN) && !imem_rvalid);
    assign imem_req  = (state == REQ) && !rst;
    assign imem_addr = {pc[31:2], 2'b00};
    assign valid_if  = (state == OUT);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        mis_n   = mis_q;
        instr_n = instruction_if;
        addr_n  = instruction_addr_if;
        exc_n   = exception_if;
        if (redirect) begin
            pc_n  = mis_tgt ? redirect_pc : {redirect_pc[31:2], 2'b00};
            mis_n = mis_tgt;
            if (busy) begin
                state_n = DRAIN;
            end else if (mis_tgt) begin
                state_n    = OUT;
                instr_n    = '0;
                addr_n     = redirect_pc;
                exc_n.raise = 1'b1;
                exc_n.code  = INSTR_ADDR_MISALIGNED;
            end else begin
                state_n = REQ;
            end
        end else begin
            unique case (state)
                REQ: state_n = imem_gnt ? WAIT : REQ;
                WAIT: if (imem_rvalid) begin
                    state_n     = OUT;
                    instr_n     = imem_rdata;
                    addr_n      = pc;
                    exc_n.raise = imem_err;
                    exc_n.code  = imem_err ? INSTR_ACCESS_FAULT : 5'd0;
                end
                OUT: if (!stall_id) begin
                    state_n = exception_if.raise ? FAULT : REQ;
                    pc_n    = exception_if.raise ? pc : pc + 32'd4;
                end
                DRAIN: if (imem_rvalid) begin
                    state_n = mis_q ? OUT : REQ;
                    if (mis_q) begin
                        instr_n     = '0;
                        addr_n      = pc;
                        exc_n.raise = 1'b1;
                        exc_n.code  = INSTR_ADDR_MISALIGNED;
                    end
                end
                FAULT: state_n = FAULT;
                default: state_n = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= REQ;
            pc                  <= RESET_PC;
            mis_q               <= 1'b0;
            instruction_if      <= '0;
            instruction_addr_if <= '0;
            exception_if        <= '0;
        end else begin
            state               <= state_n;
            pc                  <= pc_n;
            mis_q               <= mis_n;
            instruction_if      <= instr_n;
            instruction_addr_if <= addr_n;
            exception_if        <= exc_n;
        end
    end

    rvalid_only_when_outstanding: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (state == WAIT || state == DRAIN));

`ifdef FETCH_PERF_CNT_EN
    logic squash;
    assign squash = redirect && ((state == REQ && imem_gnt) || state == WAIT);

    fetch_perf_counter u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_inc    (state == REQ || state == WAIT),
        .squash_inc   (squash),
        .stall_cycles (fetch_stall_cycles),
        .squash_count (squash_count)
    );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: scoreboard bench for fetch_controller with a latency-programmable imem model.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst, redirect, stall_id, imem_req, imem_gnt, imem_rvalid, imem_err, valid_if;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instruction_addr_if, instruction_if;
    exception_t  exception_if;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cycles;
    logic [15:0] squash_count;
`endif

    int          n_checks = 0, n_fail = 0, lat = 1, cd = 0;
    logic [31:0] pend = '0, err_addr = 32'h1;
    logic [69:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .stall_id(stall_id),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_err(imem_err), .valid_if(valid_if),
        .instruction_addr_if(instruction_addr_if), .instruction_if(instruction_if),
        .exception_if(exception_if)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_stall_cycles(fetch_stall_cycles), .squash_count(squash_count)
`endif
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_if) return;
        end
        chk({name, "_timeout"}, 70'd0, 70'd1);
    endtask

    task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input logic r, input logic [4:0] c);
        exp_q.push_back({a, d, r, c});
        imem_gnt = 1'b1;
        wait_valid("fetch");
        tick();
        imem_gnt = 1'b0;
    endtask

    // Memory responds lat cycles after each grant; grants observed at the negedge before the edge.
    initial begin
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_err    = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem(pend);
                    imem_err    = (pend == err_addr);
                end
            end
            if (imem_req && imem_gnt) begin
                pend = imem_addr;
                cd   = lat;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && valid_if) begin
                if (exp_q.size() == 0) chk("sb_unexpected_valid", {instruction_addr_if, instruction_if, exception_if}, 70'd0);
                else begin
                    chk("sb_word", {instruction_addr_if, instruction_if, exception_if}, exp_q[0]);
                    if (!stall_id) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall_id = 1'b0; imem_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", valid_if, 0);
        chk("rst_outs", {instruction_addr_if, instruction_if, exception_if}, 70'd0);
        // first fetch: REQ, WAIT, OUT
        exp_q.push_back({32'h0, 32'h13, 6'h0});
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        @(negedge clk);
        chk("t1_valid_c2", valid_if, 0);
        @(negedge clk);
        chk("t1_valid_c3", valid_if, 1);
        tick();
        imem_gnt = 1'b0;
        chk("t1_next_addr", {imem_req, imem_addr}, {1'b1, 32'h4});
        // stall held in OUT
        stall_id = 1'b1;
        exp_q.push_back({32'h4, mem(32'h4), 6'h0});
        imem_gnt = 1'b1;
        wait_valid("t2");
        for (int i = 0; i < 4; i++) begin
            tick();
            imem_gnt = 1'b0;
            chk("t2_stall", {valid_if, imem_req, imem_addr}, {1'b1, 1'b0, 32'h4});
        end
        stall_id = 1'b0;
        tick();
        chk("t2_release", {imem_req, imem_addr}, {1'b1, 32'h8});
        // redirect while waiting: stale word dropped via DRAIN
        lat = 3; imem_gnt = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h100; imem_gnt = 1'b0;
        tick();
        redirect = 1'b0;
        chk("t3_drain", {valid_if, imem_req}, 2'b00);
        tick();
        tick();
        chk("t3_req", {imem_req, imem_addr}, {1'b1, 32'h100});
        lat = 1;
        fetch_one(32'h100, mem(32'h100), 1'b0, 5'd0);
        // misaligned redirect
        exp_q.push_back({32'h102, 32'h0, 1'b1, INSTR_ADDR_MISALIGNED});
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        chk("t4_no_req", imem_req, 0);
        wait_valid("t4");
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t4_fault", {valid_if, imem_req}, 2'b00);
            tick();
        end
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("t4_req", {imem_req, imem_addr}, {1'b1, 32'h200});
        fetch_one(32'h200, mem(32'h200), 1'b0, 5'd0);
        // bus error
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; err_addr = 32'h40;
        fetch_one(32'h40, mem(32'h40), 1'b1, INSTR_ACCESS_FAULT);
        for (int i = 0; i < 2; i++) begin
            chk("t5_fault", {valid_if, imem_req}, 2'b00);
            tick();
        end
        err_addr = 32'h1;
        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'hFFFF_FC13, 1'b0, 5'd0);
        chk("t6_wrap", {imem_req, imem_addr}, {1'b1, 32'h0});
        // misaligned redirect during WAIT: drain first, then exception
        lat = 2; imem_gnt = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h306; imem_gnt = 1'b0;
        exp_q.push_back({32'h306, 32'h0, 1'b1, INSTR_ADDR_MISALIGNED});
        tick();
        redirect = 1'b0;
        chk("t7_drain", {valid_if, imem_req}, 2'b00);
        wait_valid("t7");
        tick();
        chk("t7_fault", {valid_if, imem_req}, 2'b00);
        // redirect coincident with grant
        redirect = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_pc = 32'h50; imem_gnt = 1'b1; lat = 1;
        tick();
        redirect = 1'b0; imem_gnt = 1'b0;
        chk("t8_drain", {valid_if, imem_req}, 2'b00);
        tick();
        chk("t8_req", {imem_req, imem_addr}, {1'b1, 32'h50});
        fetch_one(32'h50, mem(32'h50), 1'b0, 5'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_squash", squash_count, 16'd3);
        chk("perf_stall_nonzero", fetch_stall_cycles != 0, 1);
`endif
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch for the RISC-V core.
- Owns the PC register and issues single-outstanding requests to instruction memory over a req/gnt/rvalid bus.
- Presents fetched words to IF_ID with a valid/stall handshake.
- Handles redirects (branch/trap) and raises fetch exceptions through exception_t.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MISALIGN_CHECK, 1, 1 = raise an exception for redirect_pc[1:0] != 0; 0 = force the low bits to 0.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- redirect  input  1  load redirect_pc; squashes the current fetch
- redirect_pc  input  32  redirect target
- stall_id  input  1  IF_ID cannot accept this cycle
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address (word-aligned)
- imem_gnt  input  1  request accepted
- imem_rvalid  input  1  response valid; at least 1 cycle after gnt
- imem_rdata  input  32  instruction word
- imem_err  input  1  bus error, qualified by rvalid
- valid_if  output  1  instruction_if / instruction_addr_if / exception_if valid
- instruction_addr_if  output  32  PC of the presented word
- instruction_if  output  32  presented instruction
- exception_if  output  exception_t  {raise, code}

Behaviour:
- Reset (asynchronous) values: pc=RESET_PC, state=REQ, imem_req=0 while rst is high, valid_if=0, instruction_if=0, instruction_addr_if=0, exception_if='0.
- State REQ:
  - imem_req=1, imem_addr=pc.
  - On gnt → WAIT.
  - Address may change while ungranted: a redirect without gnt updates pc and stays in REQ.
- State WAIT:
  - On rvalid, capture rdata/err and pc → OUT.
  - err=1 → exception_if.raise=1, code=INSTR_ACCESS_FAULT (1).
- State OUT:
  - valid_if=1; outputs held stable while stall_id=1.
  - Accept = valid_if & ~stall_id.
  - On accept without fault: pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0), → REQ.
  - On accept with raise=1: → FAULT.
- State FAULT:
  - valid_if=0, imem_req=0; wait for redirect.
- State DRAIN:
  - imem_req=0; discard the next rvalid, then → REQ with the stored pc.
  - A further redirect in DRAIN only updates pc.
- Redirect (highest priority, any state):
  - pc ← redirect_pc; valid_if forced 0 next cycle.
  - Next state: REQ from REQ without gnt, OUT, or FAULT; DRAIN from WAIT without rvalid, or REQ with gnt in the same cycle.
  - From WAIT with rvalid in the same cycle: the response is dropped, → REQ.
- Misaligned target (MISALIGN_CHECK=1, redirect_pc[1:0]!=0):
  - No bus request is issued; → OUT with raise=1, code=INSTR_ADDR_MISALIGNED (0), instruction_addr_if=redirect_pc, instruction_if=0.
  - If the redirect arrives from WAIT, it waits for DRAIN completion first.
- Latency: minimum 3 cycles from entering REQ to valid_if (REQ, WAIT, OUT); one outstanding request maximum.
- rvalid in REQ, OUT, or FAULT is a protocol violation: ignored, and flagged by an assertion.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - adds outputs fetch_stall_cycles[31:0] (counts cycles in REQ or WAIT, saturating at 0xFFFF_FFFF) and squash_count[15:0] (counts redirects that discard a granted request, saturating).
  - Both counters clear on rst.
- Undefined: neither port nor counter exists.

Decomposition:
- Exception_Pkg: exception_t, and constants INSTR_ADDR_MISALIGNED=0 and INSTR_ACCESS_FAULT=1.
- Fetch_Pkg: fetch_state_t enum {REQ, WAIT, OUT, DRAIN, FAULT}.
- Sub-module: fetch_perf_counter (saturating counter pair), instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Reset release with gnt tied 1, rvalid 1 cycle later with rdata 0x0000_0013 → valid_if in cycle 3 with addr 0x0, then next req addr 0x4.
- stall_id held 4 cycles in OUT → outputs stable, no imem_req, pc unchanged until release.
- redirect to 0x100 in WAIT (rvalid 2 cycles later) → stale word never presented; DRAIN, then req addr 0x100.
- redirect to 0x102 → no imem_req; valid_if with raise=1, code 0, addr 0x102; after accept, FAULT until redirect to 0x200.
- rvalid with imem_err=1 at pc 0x40 → raise=1, code 1, addr 0x40; FAULT after accept.
- pc=0xFFFF_FFFC accepted → next imem_addr 0x0000_0000.
